// File: rtl/note_envelope_pkg.sv
// Shared envelope definitions: state encodings and gain ceiling.
package envelope_defs;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    localparam logic [15:0] GAIN_MAX = 16'hFFFF;

endpackage

// File: rtl/envelope_gen.sv
// ADSR gain state machine advanced on beat, with note_done edge detect.
module envelope_gen
    import envelope_defs::*;
#(
    parameter logic [15:0] ATTACK_STEP   = 16'd8192,
    parameter logic [15:0] DECAY_STEP    = 16'd4096,
    parameter logic [15:0] SUSTAIN_LEVEL = 16'd49152,
    parameter logic [15:0] RELEASE_STEP  = 16'd2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        beat,
    input  logic        note_start,
    input  logic        note_done,
    output logic [15:0] gain,
    output env_state_t  state
);

    if (ATTACK_STEP == 16'd0) begin : g_bad_attack
        $error("ATTACK_STEP must be >= 1");
    end
    if (DECAY_STEP == 16'd0) begin : g_bad_decay
        $error("DECAY_STEP must be >= 1");
    end
    if (SUSTAIN_LEVEL == GAIN_MAX) begin : g_bad_sustain
        $error("SUSTAIN_LEVEL must be < 16'hFFFF");
    end
    if (RELEASE_STEP == 16'd0) begin : g_bad_release
        $error("RELEASE_STEP must be >= 1");
    end

    env_state_t  state_n;
    logic [15:0] gain_n;
    logic        done_q;
    logic        done_rise;
    logic        gated;
    logic [16:0] sum;
    logic [16:0] decay_lim;

    assign done_rise = note_done & ~done_q;
    assign gated     = (state == ATTACK) || (state == DECAY)
                    || (state == SUSTAIN);
    assign sum       = {1'b0, gain} + {1'b0, ATTACK_STEP};
    assign decay_lim = {1'b0, SUSTAIN_LEVEL} + {1'b0, DECAY_STEP};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            gain   <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            gain   <= gain_n;
            done_q <= note_done;
        end
    end

    // A state-changing event suppresses the beat step for that cycle.
    always_comb begin
        state_n = state;
        gain_n  = gain;
        if (note_start) begin
            state_n = ATTACK;
        end else if (done_rise && gated) begin
            state_n = RELEASE;
        end else if (beat) begin
            case (state)
                IDLE: gain_n = '0;
                ATTACK: begin
                    if (sum >= {1'b0, GAIN_MAX}) begin
                        gain_n  = GAIN_MAX;
                        state_n = DECAY;
                    end else begin
                        gain_n = sum[15:0];
                    end
                end
                DECAY: begin
                    if ({1'b0, gain} <= decay_lim) begin
                        gain_n  = SUSTAIN_LEVEL;
                        state_n = SUSTAIN;
                    end else begin
                        gain_n = gain - DECAY_STEP;
                    end
                end
                RELEASE: begin
                    if (gain <= RELEASE_STEP) begin
                        gain_n  = '0;
                        state_n = IDLE;
                    end else begin
                        gain_n = gain - RELEASE_STEP;
                    end
                end
                default: gain_n = gain;
            endcase
        end
    end

endmodule

// File: rtl/note_envelope.sv
// Per-voice envelope: scales each captured voice sample by the ADSR gain.
module note_envelope
    import envelope_defs::*;
#(
    parameter logic [15:0] ATTACK_STEP   = 16'd8192,
    parameter logic [15:0] DECAY_STEP    = 16'd4096,
    parameter logic [15:0] SUSTAIN_LEVEL = 16'd49152,
    parameter logic [15:0] RELEASE_STEP  = 16'd2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        beat,
    input  logic        note_start,
    input  logic        note_done,
    input  logic [15:0] sample_in,
    input  logic        sample_in_ready,
    output logic [15:0] sample_out,
    output logic        new_sample_ready,
    output logic [15:0] gain,
    output logic [2:0]  env_state
);

    env_state_t         st;
    logic               rdy_q;
    logic               cap_valid;
    logic [15:0]        cap_sample;
    logic [15:0]        cap_gain;
    logic signed [31:0] prod;
    logic [15:0]        prod_hi;
    logic [15:0]        unused_lo;

    envelope_gen #(
        .ATTACK_STEP  (ATTACK_STEP),
        .DECAY_STEP   (DECAY_STEP),
        .SUSTAIN_LEVEL(SUSTAIN_LEVEL),
        .RELEASE_STEP (RELEASE_STEP)
    ) u_gen (
        .clk       (clk),
        .reset     (reset),
        .beat      (beat),
        .note_start(note_start),
        .note_done (note_done),
        .gain      (gain),
        .state     (st)
    );

    assign env_state = st;

    // Gain is zero-extended so it stays positive in the signed multiply.
    assign prod = $signed({{16{cap_sample[15]}}, cap_sample})
                * $signed({16'b0, cap_gain});
    assign {prod_hi, unused_lo} = prod;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_q            <= 1'b0;
            cap_valid        <= 1'b0;
            cap_sample       <= '0;
            cap_gain         <= '0;
            sample_out       <= '0;
            new_sample_ready <= 1'b0;
        end else begin
            rdy_q            <= sample_in_ready;
            cap_valid        <= sample_in_ready & ~rdy_q;
            new_sample_ready <= cap_valid;
            if (sample_in_ready && !rdy_q) begin
                cap_sample <= sample_in;
                cap_gain   <= gain;
            end
            if (cap_valid) begin
                sample_out <= prod_hi;
            end
        end
    end

endmodule

// File: tb/tb_note_envelope.sv
// Randomised and directed bench for note_envelope against a behavioural model.
module tb_note_envelope;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        beat = 1'b0;
    logic        note_start = 1'b0;
    logic        note_done = 1'b0;
    logic [15:0] sample_in = '0;
    logic        sample_in_ready = 1'b0;
    logic [15:0] sample_out;
    logic        new_sample_ready;
    logic [15:0] gain;
    logic [2:0]  env_state;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    bit run = 0;

    // Model state
    int   m_state, m_gain, m_out;
    bit   m_done_prev, m_rdy_prev, m_d1v, m_rdy;
    int   m_d1;

    note_envelope dut (
        .clk             (clk),
        .reset           (reset),
        .beat            (beat),
        .note_start      (note_start),
        .note_done       (note_done),
        .sample_in       (sample_in),
        .sample_in_ready (sample_in_ready),
        .sample_out      (sample_out),
        .new_sample_ready(new_sample_ready),
        .gain            (gain),
        .env_state       (env_state)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int scale(logic [15:0] s, int g);
        longint p;
        longint q;
        logic [15:0] r;
        p = longint'($signed(s)) * longint'(g);
        q = p >>> 16;
        r = q[15:0];
        return int'(r);
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    // Reference: states 0..4 = idle/attack/decay/sustain/release.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state = 0; m_gain = 0; m_out = 0;
            m_done_prev = 0; m_rdy_prev = 0;
            m_d1v = 0; m_d1 = 0; m_rdy = 0;
        end else begin
            m_rdy = m_d1v;
            if (m_d1v) m_out = m_d1;
            m_d1v = sample_in_ready && !m_rdy_prev;
            if (m_d1v) m_d1 = scale(sample_in, m_gain);
            if (note_start) begin
                m_state = 1;
            end else if (note_done && !m_done_prev
                         && m_state >= 1 && m_state <= 3) begin
                m_state = 4;
            end else if (beat) begin
                if (m_state == 1) begin
                    m_gain = imin(m_gain + 8192, 65535);
                    if (m_gain == 65535) m_state = 2;
                end else if (m_state == 2) begin
                    m_gain = imax(m_gain - 4096, 49152);
                    if (m_gain == 49152) m_state = 3;
                end else if (m_state == 4) begin
                    m_gain = imax(m_gain - 2048, 0);
                    if (m_gain == 0) m_state = 0;
                end
            end
            m_done_prev = note_done;
            m_rdy_prev = sample_in_ready;
        end
    end

    always @(negedge clk) begin
        if (new_sample_ready) pulses++;
        if (run) begin
            check("gain", int'(gain), m_gain);
            check("env_state", int'(env_state), m_state);
            check("new_sample_ready", int'(new_sample_ready), int'(m_rdy));
            check("sample_out", int'(sample_out), m_out);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beats(int n);
        repeat (n) begin
            beat = 1'b1; step();
            beat = 1'b0; step();
        end
    endtask

    task automatic pulse_start();
        note_start = 1'b1; step();
        note_start = 1'b0;
    endtask

    // Capture one sample and check the 2-cycle pulse timing and value.
    task automatic scale_test(string name, logic [15:0] s, int exp);
        sample_in = s;
        sample_in_ready = 1'b1; step();
        check({name, "_early"}, int'(new_sample_ready), 0);
        sample_in_ready = 1'b0; step();
        check({name, "_pulse"}, int'(new_sample_ready), 1);
        check(name, int'(sample_out), exp);
        step();
        check({name, "_pulse_end"}, int'(new_sample_ready), 0);
        check({name, "_hold"}, int'(sample_out), exp);
    endtask

    initial begin
        int p0;
        #1 reset = 1'b0;
        step(); step();
        check("rst_gain", int'(gain), 0);
        check("rst_state", int'(env_state), 0);
        check("rst_out", int'(sample_out), 0);
        check("rst_nsr", int'(new_sample_ready), 0);
        run = 1;
        reset = 1'b1; step();

        // Scaling at gain 32768
        pulse_start();
        beats(4);
        check("gain_32768", int'(gain), 32768);
        scale_test("scale_pos", 16'h7FFF, 16'h3FFF);
        scale_test("scale_neg", 16'h8000, 16'hC000);

        // Simultaneous events
        note_start = 1'b1; note_done = 1'b1; step();
        note_start = 1'b0;
        check("start_vs_done", int'(env_state), 1);
        note_start = 1'b1; beat = 1'b1; step();
        note_start = 1'b0; beat = 1'b0;
        check("start_vs_beat", int'(gain), 32768);
        note_done = 1'b0; step();

        // Held ready gives a single pulse
        p0 = pulses;
        sample_in = 16'h1234;
        sample_in_ready = 1'b1;
        repeat (10) step();
        sample_in_ready = 1'b0;
        repeat (3) step();
        check("held_ready_pulses", pulses - p0, 1);

        // Reset mid-envelope with a capture in flight
        beats(3);
        check("gain_57344", int'(gain), 57344);
        sample_in = 16'h7FFF;
        sample_in_ready = 1'b1; step();
        #2 reset = 1'b0;
        #1;
        check("midrst_gain", int'(gain), 0);
        check("midrst_state", int'(env_state), 0);
        check("midrst_out", int'(sample_out), 0);
        check("midrst_nsr", int'(new_sample_ready), 0);
        sample_in_ready = 1'b0;
        step(); step();
        reset = 1'b1;
        p0 = pulses;
        repeat (5) step();
        check("post_rst_pulses", pulses - p0, 0);

        // Full ADSR with retrigger
        pulse_start();
        beats(8);
        check("attack_peak", int'(gain), 65535);
        check("attack_to_decay", int'(env_state), 2);
        beats(4);
        check("sustain_gain", int'(gain), 49152);
        check("sustain_state", int'(env_state), 3);
        scale_test("scale_sustain", 16'h7FFF, 16'h5FFF);
        note_done = 1'b1; step();
        check("release_state", int'(env_state), 4);
        beats(14);
        check("release_20480", int'(gain), 20480);
        pulse_start();
        check("retrigger_state", int'(env_state), 1);
        beats(1);
        check("retrigger_gain", int'(gain), 28672);
        note_done = 1'b0; step();
        beats(5);
        check("reattack_peak", int'(gain), 65535);
        beats(4);
        check("resustain", int'(gain), 49152);
        note_done = 1'b1; step();
        beats(24);
        check("release_end_gain", int'(gain), 0);
        check("release_end_state", int'(env_state), 0);
        scale_test("idle_scale", 16'h7FFF, 0);
        note_done = 1'b0; step();

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            beat = ($urandom_range(0, 5) == 0);
            note_start = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 39) == 0) note_done = ~note_done;
            sample_in = 16'($urandom);
            sample_in_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 999) == 0) begin
                reset = 1'b0; step();
                reset = 1'b1;
            end
            step();
        end
        beat = 1'b0; note_start = 1'b0; sample_in_ready = 1'b0;
        step(); step();
        run = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_envelope.md
# note_envelope

Per-voice amplitude envelope stage between a `note_player` voice and the codec/mixer. It runs an attack–decay–sustain–release (ADSR) gain state machine, advanced on the 1/48 s `beat`, triggered by the same `load_new_note` / `done_with_note` signals the voice uses. Each raw voice sample is scaled by the current gain and re-published to the codec with its own ready pulse.

## Interface
- `ATTACK_STEP`, default 16'd8192: gain increment per beat in ATTACK. Must be ≥1.
- `DECAY_STEP`, default 16'd4096: gain decrement per beat in DECAY. Must be ≥1.
- `SUSTAIN_LEVEL`, default 16'd49152: held gain in SUSTAIN. Must be <16'hFFFF.
- `RELEASE_STEP`, default 16'd2048: gain decrement per beat in RELEASE. Must be ≥1.
- Any parameter outside its stated range is an elaboration-time error.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `beat` in 1: one-cycle 1/48 s tick.
- `note_start` in 1: one-cycle pulse; wired to the voice's `load_new_note`.
- `note_done` in 1: level; wired to the voice's `done_with_note`.
- `sample_in` in 16: signed voice sample (the voice's `sample_out`).
- `sample_in_ready` in 1: the voice's `new_sample_ready` (level).
- `sample_out` out 16: signed scaled sample.
- `new_sample_ready` out 1: one-cycle pulse when `sample_out` updates.
- `gain` out 16: current unsigned gain; 16'hFFFF ≈ 1.0.
- `env_state` out 3: current state encoding.

## Operation
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. Gain changes only on a cycle with `beat`=1, and by at most one step per beat.
- IDLE: gain is held at 0.
- ATTACK: gain = min(gain+ATTACK_STEP, 16'hFFFF), computed with a 17-bit intermediate. Reaching 16'hFFFF moves to DECAY.
- DECAY: gain = max(gain−DECAY_STEP, SUSTAIN_LEVEL). Reaching SUSTAIN_LEVEL moves to SUSTAIN.
- SUSTAIN: gain is held.
- RELEASE: gain = max(gain−RELEASE_STEP, 0). Reaching 0 moves to IDLE.
- `note_start` in any state enters ATTACK from the current gain (retrigger, no reset to 0).
- A `note_done` rising edge (0→1) in ATTACK, DECAY or SUSTAIN enters RELEASE. It is ignored in IDLE and RELEASE.
- Priority: `note_start` > `note_done` edge > beat update.
  - A cycle that changes state applies no gain step.
  - The state transition triggered by a step reaching its bound happens in the same cycle as that step.
- Datapath:
  - A `sample_in_ready` rising edge in cycle N captures `sample_in` and the current gain.
  - Cycle N+1: product = signed(`sample_in`) × signed({1'b0, gain}), 33 bits. The result is product[31:16] (arithmetic >>16); it cannot overflow and is registered.
  - `new_sample_ready`=1 during N+2 only. `sample_out` holds until the next update.
- If `sample_in_ready` is held high, only one capture occurs per rising edge.

## Timing
- Reset (asynchronous, immediate): state IDLE, `gain`=0, `sample_out`=0, `new_sample_ready`=0, and all edge-detect registers 0.
- Reset asserted mid-envelope or mid-pipeline discards all in-flight work. No `new_sample_ready` pulse follows reset release until a fresh `sample_in_ready` edge.
- Latency: `sample_in_ready` edge to `new_sample_ready` is 2 cycles. Event to state change is 1 cycle (visible on `env_state` the next cycle).
- Back-to-back captures are legal every 2 cycles (the minimum gap between `sample_in_ready` rising edges). Pipeline stages are independent.

## Structure
- Shared header `envelope_defs`:
  - state encodings IDLE=3'd0, ATTACK=3'd1, DECAY=3'd2, SUSTAIN=3'd3, RELEASE=3'd4;
  - `GAIN_MAX`=16'hFFFF.
- Sub-module `envelope_gen` contains the FSM, saturating gain arithmetic and `note_done` edge detect.
- `note_envelope` top contains the capture/multiply pipeline.

## Test plan
All scenarios use default parameters.
- Full ADSR:
  - `note_start`, then 8 beats → gain reaches 16'hFFFF (state DECAY).
  - 4 more beats → gain 49152 (SUSTAIN; the 4th step clamps from 49151).
  - Raise `note_done` → RELEASE; 24 beats → gain 0, IDLE.
- Scaling:
  - gain 32768 (4 attack beats), `sample_in` 16'h7FFF → `sample_out` 16'h3FFF.
  - Same gain, 16'h8000 → 16'hC000.
  - Each result appears with `new_sample_ready` high for exactly one cycle, 2 cycles after the edge.
- Retrigger:
  - `note_start` during RELEASE at gain 20480 → ATTACK.
  - Next beat → gain 28672.
- Simultaneous events:
  - `note_start` and a `note_done` rise in the same cycle → ATTACK.
  - `note_start` coincident with `beat` → gain unchanged that cycle.
- Held ready / IDLE:
  - `sample_in_ready` high for 10 cycles → exactly one output pulse.
  - In IDLE, `sample_in` 16'h7FFF → `sample_out` 0.
- Reset mid-operation:
  - Deassert `reset` after 3 attack beats, with a capture in flight → all outputs 0 immediately.
  - No ready pulse after reset release.
